ntsc_vram_arbiter: RTL and testbench

Single-port video RAM arbiter for the NTSC test-pattern generator. It shares one synchronous pixel SRAM between two requesters. The scanout requester is hard real-time: it fetches pixel data during the active period and is never stalled. The host requester is a register or CPU port that writes and reads the frame buffer; its writes are posted through a small buffer and drain into unused memory cycles. The block sits between the line/pixel counters of the generator, the host bus and the SRAM macro.

---
 rtl/ntsc_pkg.sv | 12 +
 rtl/ntsc_wbuf.sv | 40 ++++
 rtl/ntsc_vram_arbiter.sv | 123 ++++++++++++
 tb/tb_ntsc_vram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntsc_pkg.sv
// Shared constants and types for the NTSC test-pattern generator and its VRAM arbiter.
package ntsc_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;

    localparam logic [7:0] LVL_SYNC  = 8'h00;
    localparam logic [7:0] LVL_BLACK = 8'h48;
    localparam logic [7:0] LVL_WHITE = 8'hFF;

    // Per-cycle SRAM grant; registered one cycle to steer the returning read data.
    typedef enum logic [1:0] {OWN_IDLE, OWN_VID, OWN_WR, OWN_RD} vram_owner_t;
endpackage

// File: rtl/ntsc_wbuf.sv
// Posted-write FIFO; pointers carry an extra wrap bit so full/empty need no counter.
module ntsc_wbuf #(
    parameter int W     = 23,
    parameter int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] level_o
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + 1'b1;
            if (pop_i)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr[IDX_W-1:0]] <= din_i;
    end

    assign dout_o  = r_mem[r_rptr[IDX_W-1:0]];
    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]) && (r_wptr[IDX_W] != r_rptr[IDX_W]);
    assign level_o = r_wptr - r_rptr;
endmodule

// File: rtl/ntsc_vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, posted host writes drain into
// free cycles, host reads wait for an empty write buffer so they see earlier writes.
module ntsc_vram_arbiter #(
    parameter int ADDR_W     = ntsc_pkg::DEF_ADDR_W,
    parameter int DATA_W     = ntsc_pkg::DEF_DATA_W,
    parameter int WBUF_DEPTH = 4,
    localparam int LVL_W     = $clog2(WBUF_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [DATA_W-1:0] vid_data_o,
    output logic              vid_valid_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ready_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [LVL_W-1:0]  wbuf_level_o
);
    import ntsc_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    vram_owner_t       w_grant;
    vram_owner_t       r_owner;
    wr_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              r_rd_pending;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_vid_data;
    logic [DATA_W-1:0] r_host_rdata;

    assign host_ready_o = !r_rd_pending && !w_full && !rst_i;
    assign w_accept     = host_req_i && host_ready_o;
    assign w_push       = w_accept && host_we_i;
    assign w_pop        = (w_grant == OWN_WR);

    ntsc_wbuf #(.W($bits(wr_entry_t)), .DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   ({host_addr_i, host_wdata_i}),
        .pop_i   (w_pop),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (wbuf_level_o)
    );

    always_comb begin
        w_grant = OWN_IDLE;
        if (rst_i)             w_grant = OWN_IDLE;
        else if (vid_req_i)    w_grant = OWN_VID;
        else if (!w_empty)     w_grant = OWN_WR;
        else if (r_rd_pending) w_grant = OWN_RD;
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (w_grant)
            OWN_VID: begin
                mem_en_o   = 1'b1;
                mem_addr_o = vid_addr_i;
            end
            OWN_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = w_head.addr;
                mem_wdata_o = w_head.data;
            end
            OWN_RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = r_rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner      <= OWN_IDLE;
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
            r_vid_data   <= '0;
            r_host_rdata <= '0;
        end else begin
            r_owner <= w_grant;
            if (w_accept && !host_we_i) begin
                r_rd_pending <= 1'b1;
                r_rd_addr    <= host_addr_i;
            end else if (w_grant == OWN_RD) begin
                r_rd_pending <= 1'b0;
            end
            if (r_owner == OWN_VID) r_vid_data   <= mem_rdata_i;
            if (r_owner == OWN_RD)  r_host_rdata <= mem_rdata_i;
        end
    end

    // SRAM data arrives the cycle after the grant, so the valid cycle passes it straight through.
    assign vid_valid_o   = (r_owner == OWN_VID);
    assign host_rvalid_o = (r_owner == OWN_RD);
    assign vid_data_o    = vid_valid_o   ? mem_rdata_i : r_vid_data;
    assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : r_host_rdata;
endmodule

// File: tb/tb_ntsc_vram_arbiter.sv
// Directed bench for ntsc_vram_arbiter with a behavioural synchronous SRAM.
module tb_ntsc_vram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          vid_req_i = 1'b0;
    logic [AW-1:0] vid_addr_i = '0;
    logic [DW-1:0] vid_data_o;
    logic          vid_valid_o;
    logic          host_req_i = 1'b0;
    logic          host_we_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [DW-1:0] host_wdata_i = '0;
    logic          host_ready_o;
    logic [DW-1:0] host_rdata_o;
    logic          host_rvalid_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [2:0]    wbuf_level_o;

    always #5 clk = ~clk;

    ntsc_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i),
        .vid_data_o(vid_data_o), .vid_valid_o(vid_valid_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_ready_o(host_ready_o), .host_rdata_o(host_rdata_o),
        .host_rvalid_o(host_rvalid_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .wbuf_level_o(wbuf_level_o)
    );

    function automatic logic [7:0] f(input int a);
        return 8'((a * 3) ^ (a >> 8) ^ 8'h21);
    endfunction

    // Behavioural SRAM, preloaded with f(addr) while reset is first held.
    logic [7:0] sram [0:32767];
    bit         loaded = 1'b0;
    int         wr_count = 0;
    int         rv_count = 0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) sram[i] <= f(i);
            loaded <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i <= sram[mem_addr_o];
        end
        if (mem_en_o && mem_we_o) wr_count <= wr_count + 1;
        if (host_rvalid_o)        rv_count <= rv_count + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic          vid;
        logic [AW-1:0] vaddr;
        logic          hreq;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hdata;
        logic          en;
        logic          we;
        logic [AW-1:0] maddr;
        logic [DW-1:0] wdata;
        logic          ready;
        logic [2:0]    level;
        logic          vvalid;
        logic [DW-1:0] vdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Full-buffer under continuous scanout, then in-order drain.
        vecs[0]  = '{1, 15'h010, 1, 15'h100, 8'hAA, 1, 0, 15'h010, 8'h00, 1, 3'd0, 0, f(16'h2EF)};
        vecs[1]  = '{1, 15'h011, 1, 15'h101, 8'hBB, 1, 0, 15'h011, 8'h00, 1, 3'd1, 1, f(16'h010)};
        vecs[2]  = '{1, 15'h012, 1, 15'h102, 8'hCC, 1, 0, 15'h012, 8'h00, 1, 3'd2, 1, f(16'h011)};
        vecs[3]  = '{1, 15'h013, 1, 15'h103, 8'hDD, 1, 0, 15'h013, 8'h00, 1, 3'd3, 1, f(16'h012)};
        vecs[4]  = '{1, 15'h014, 1, 15'h104, 8'hEE, 1, 0, 15'h014, 8'h00, 0, 3'd4, 1, f(16'h013)};
        vecs[5]  = '{1, 15'h015, 1, 15'h104, 8'hEE, 1, 0, 15'h015, 8'h00, 0, 3'd4, 1, f(16'h014)};
        vecs[6]  = '{0, 15'h000, 0, 15'h000, 8'h00, 1, 1, 15'h100, 8'hAA, 0, 3'd4, 1, f(16'h015)};
        vecs[7]  = '{0, 15'h000, 0, 15'h000, 8'h00, 1, 1, 15'h101, 8'hBB, 1, 3'd3, 0, f(16'h015)};
        vecs[8]  = '{0, 15'h000, 0, 15'h000, 8'h00, 1, 1, 15'h102, 8'hCC, 1, 3'd2, 0, f(16'h015)};
        vecs[9]  = '{0, 15'h000, 0, 15'h000, 8'h00, 1, 1, 15'h103, 8'hDD, 1, 3'd1, 0, f(16'h015)};
        vecs[10] = '{0, 15'h000, 0, 15'h000, 8'h00, 0, 0, 15'h000, 8'h00, 1, 3'd0, 0, f(16'h015)};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(host_ready_o), 0);
        chk("rst_mem_en", 32'(mem_en_o), 0);
        chk("rst_mem_we", 32'(mem_we_o), 0);
        chk("rst_vvalid", 32'(vid_valid_o), 0);
        chk("rst_rvalid", 32'(host_rvalid_o), 0);
        chk("rst_vdata", 32'(vid_data_o), 0);
        chk("rst_rdata", 32'(host_rdata_o), 0);
        chk("rst_level", 32'(wbuf_level_o), 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(host_ready_o), 1);
        chk("idle_mem_en", 32'(mem_en_o), 0);

        // Scanout only, 0x000..0x2EF back to back
        for (int a = 0; a <= 16'h2F0; a++) begin
            @(negedge clk);
            vid_req_i  = (a <= 16'h2EF);
            vid_addr_i = AW'(a);
            #1;
            if (a <= 16'h2EF) chk("scan_addr", 32'(mem_addr_o), 32'(a));
            if (a > 0) begin
                chk("scan_valid", 32'(vid_valid_o), 1);
                chk("scan_data", 32'(vid_data_o), 32'(f(a - 1)));
            end
        end
        @(negedge clk); #1;
        chk("scan_valid_end", 32'(vid_valid_o), 0);
        chk("scan_data_hold", 32'(vid_data_o), 32'(f(16'h2EF)));

        // Table: writes while scanout owns the RAM
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            vid_req_i    = vecs[i].vid;
            vid_addr_i   = vecs[i].vaddr;
            host_req_i   = vecs[i].hreq;
            host_we_i    = 1'b1;
            host_addr_i  = vecs[i].haddr;
            host_wdata_i = vecs[i].hdata;
            #1;
            chk($sformatf("v%0d_en", i), 32'(mem_en_o), 32'(vecs[i].en));
            chk($sformatf("v%0d_we", i), 32'(mem_we_o), 32'(vecs[i].we));
            if (vecs[i].en) chk($sformatf("v%0d_addr", i), 32'(mem_addr_o), 32'(vecs[i].maddr));
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), 32'(mem_wdata_o), 32'(vecs[i].wdata));
            chk($sformatf("v%0d_ready", i), 32'(host_ready_o), 32'(vecs[i].ready));
            chk($sformatf("v%0d_level", i), 32'(wbuf_level_o), 32'(vecs[i].level));
            chk($sformatf("v%0d_vvalid", i), 32'(vid_valid_o), 32'(vecs[i].vvalid));
            chk($sformatf("v%0d_vdata", i), 32'(vid_data_o), 32'(vecs[i].vdata));
        end
        host_we_i = 1'b0;
        chk("sram_100", 32'(sram[16'h100]), 32'h AA);
        chk("sram_103", 32'(sram[16'h103]), 32'h DD);
        chk("sram_104_untouched", 32'(sram[16'h104]), 32'(f(16'h104)));

        // Write then read-back of the same address behind 10 cycles of scanout
        @(negedge clk);
        vid_req_i = 1'b1; vid_addr_i = 15'h020;
        host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 15'h200; host_wdata_i = 8'h5A;
        #1; chk("wr_ready", 32'(host_ready_o), 1);
        @(negedge clk);
        vid_addr_i = 15'h021; host_we_i = 1'b0;
        #1;
        chk("rd_ready", 32'(host_ready_o), 1);
        chk("defer_addr", 32'(mem_addr_o), 32'h021);
        chk("defer_we", 32'(mem_we_o), 0);
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            host_req_i = 1'b0; vid_addr_i = AW'(16'h020 + c);
        end
        #1;
        chk("rd_pending_ready", 32'(host_ready_o), 0);
        chk("rd_wait_level", 32'(wbuf_level_o), 1);
        @(negedge clk);
        vid_req_i = 1'b0;
        #1;
        chk("wr_first_we", 32'(mem_we_o), 1);
        chk("wr_first_addr", 32'(mem_addr_o), 32'h200);
        @(negedge clk); #1;
        chk("rd_issue_en", 32'(mem_en_o), 1);
        chk("rd_issue_we", 32'(mem_we_o), 0);
        chk("rd_issue_addr", 32'(mem_addr_o), 32'h200);
        chk("rd_no_early_rvalid", 32'(host_rvalid_o), 0);
        @(negedge clk); #1;
        chk("rd_rvalid", 32'(host_rvalid_o), 1);
        chk("rd_rdata", 32'(host_rdata_o), 32'h5A);
        chk("rd_ready_again", 32'(host_ready_o), 1);
        @(negedge clk); #1;
        chk("rvalid_pulse", 32'(host_rvalid_o), 0);
        chk("rdata_hold", 32'(host_rdata_o), 32'h5A);

        // Minimum-latency read on an idle RAM
        @(negedge clk);
        host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 15'h104;
        @(negedge clk);
        host_req_i = 1'b0;
        #1; chk("fast_rd_addr", 32'(mem_addr_o), 32'h104);
        @(negedge clk); #1;
        chk("fast_rvalid", 32'(host_rvalid_o), 1);
        chk("fast_rdata", 32'(host_rdata_o), 32'(f(16'h104)));

        // Reset with three buffered writes and a pending read
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vid_req_i = 1'b1; vid_addr_i = AW'(16'h040 + i);
            host_req_i = 1'b1; host_we_i = (i < 3);
            host_addr_i = AW'(16'h300 + (i < 3 ? i : 0));
            host_wdata_i = 8'((i + 1) * 8'h11);
        end
        @(negedge clk);
        host_req_i = 1'b0;
        #1;
        chk("pre_rst_level", 32'(wbuf_level_o), 3);
        chk("pre_rst_ready", 32'(host_ready_o), 0);
        begin
            int wc0, rv0;
            wc0 = wr_count; rv0 = rv_count;
            #2 rst_i = 1'b1;
            #1;
            chk("mid_rst_level", 32'(wbuf_level_o), 0);
            chk("mid_rst_en", 32'(mem_en_o), 0);
            chk("mid_rst_ready", 32'(host_ready_o), 0);
            @(negedge clk); vid_req_i = 1'b0;
            @(negedge clk); rst_i = 1'b0;
            @(posedge clk); #1;
            chk("post_rst_ready", 32'(host_ready_o), 1);
            repeat (10) @(negedge clk);
            chk("post_rst_no_writes", 32'(wr_count - wc0), 0);
            chk("post_rst_no_rvalid", 32'(rv_count - rv0), 0);
            chk("post_rst_level", 32'(wbuf_level_o), 0);
        end
        chk("sram_300_kept", 32'(sram[16'h300]), 32'(f(16'h300)));
        chk("sram_302_kept", 32'(sram[16'h302]), 32'(f(16'h302)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
